ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; shift amount uses the low log2(XLEN) bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port StallE  input  1  hold the ID/EX register.
REQ-005 SHALL have port FlushE  input  1  load a bubble into the ID/EX register.
REQ-006 SHALL have port RD1_D  input  XLEN  decode-stage rs1 register-file value.
REQ-007 SHALL have port RD2_D  input  XLEN  decode-stage rs2 register-file value.
REQ-008 SHALL have port ImmExt_D  input  XLEN  sign-extended immediate.
REQ-009 SHALL have port PC_D  input  XLEN  instruction PC.
REQ-010 SHALL have port PCPlus4_D  input  XLEN  PC+4.
REQ-011 SHALL have port RegAddr_D  input  15  {Rs1[4:0], Rs2[4:0], Rd[4:0]}.
REQ-012 SHALL have port Ctrl_D  input  7  {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc}.
REQ-013 SHALL have port ALUControl_D  input  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt, 110 srl, 111 xor.
REQ-014 SHALL have port ForwardA_E / ForwardB_E  input  2 each  operand select from the hazard unit.
REQ-015 SHALL have port Result_W  input  XLEN  writeback-stage result, used for forwarding.
REQ-016 SHALL have port Rs1_E, Rs2_E, Rd_E  output  5 each  registered addresses, to the hazard unit.
REQ-017 SHALL have port ResultSrc0_E  output  1  ResultSrc_E[0], load-use detection.
REQ-018 SHALL have port PCSrc_E, PCTarget_E  output  1, XLEN  redirect request and redirect target.
REQ-019 SHALL have port ALUResult_M, WriteData_M, PCPlus4_M  output  XLEN each  EX/MEM data.
REQ-020 SHALL have port Rd_M, RegWrite_M, MemWrite_M, ResultSrc_M  output  5, 1, 1, 2  EX/MEM control.

Function
REQ-021 SHALL contain the ID/EX register. On each edge it loads all zeros when FlushE=1 (bubble), holds when StallE=1, and otherwise captures all *_D inputs. FlushE has priority over StallE.
REQ-022 SHALL contain the EX/MEM register, which captures every edge and is never stalled or flushed.
REQ-023 SHALL select operand SrcA/fwdB by forward code: 00 = registered RD, 01 = Result_W, 10 = ALUResult_M, 11 = treated as 00.
REQ-024 SHALL set SrcB = ALUSrc_E ? ImmExt_E : fwdB, and SHALL set WriteData_M <= fwdB.
REQ-025 SHALL compute add/sub modulo 2^XLEN. sll/srl are logical and shift by SrcB[log2(XLEN)-1:0]. slt is a signed compare with result 1 or 0, zero-extended. Zero = (result == 0).
REQ-026 SHALL compute PCTarget_E = PC_E + ImmExt_E modulo 2^XLEN, combinationally.
REQ-027 SHALL compute PCSrc_E = (Branch_E & Zero) | Jump_E, combinationally from the ID/EX state.
REQ-028 SHALL have latency of one edge from D inputs to E outputs and two edges to M outputs.
REQ-029 A bubble SHALL yield RegWrite, MemWrite, PCSrc, Jump and Branch all 0, with Rd = 0.
REQ-030 SHALL keep feeding the EX/MEM register from held ID/EX contents during StallE.
REQ-031 SHALL have no combinational path from StallE/FlushE to any output.

Reset
REQ-032 rst_n=0 SHALL asynchronously clear both pipeline registers, forcing every registered output to 0 and PCSrc_E to 0 without a clock.
REQ-033 Reset mid-operation SHALL discard all in-flight instructions. The first edge after rst_n rises SHALL capture D inputs normally.

Verification
REQ-034 Add: RD1_D=5, RD2_D=7, ALUControl_D=000, ALUSrc=0, RegWrite=1, forwards 00 -> after the 2nd edge, ALUResult_M=12 and RegWrite_M=1.
REQ-035 Branch: RD1_D=RD2_D=0x10, ALUControl_D=001, Branch=1, PC_D=0x100, ImmExt_D=0x20 -> after the 1st edge, PCSrc_E=1 and PCTarget_E=0x120. With RD2_D=0x11 -> PCSrc_E=0.
REQ-036 Forwarding: ForwardA_E=10 with ALUResult_M=12, RD2_D=3, add -> 15. ForwardB_E=01 with Result_W=0xFFFFFFFF, SrcA=0, slt -> 0. ForwardA_E=11 -> uses RD1.
REQ-037 Shift/logic: sll 1 by 0x21 -> 2. srl 0x80000000 by 31 -> 1. xor 0xF0F0 with 0xFF00 -> 0x0FF0. and/or are checked against the same operands.
REQ-038 Hazards: StallE=1 for 2 edges -> Rd_E held for 2 cycles. StallE=FlushE=1 -> bubble, giving RegWrite_M=0 one edge later. rst_n pulsed low between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of a 5-stage RISC-V pipeline: ID/EX register, operand forwarding,
// ALU, branch/jump resolution and the EX/MEM register.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic [XLEN-1:0] RD1_D,
  input  logic [XLEN-1:0] RD2_D,
  input  logic [XLEN-1:0] ImmExt_D,
  input  logic [XLEN-1:0] PC_D,
  input  logic [XLEN-1:0] PCPlus4_D,
  input  logic [14:0]     RegAddr_D,
  input  logic [6:0]      Ctrl_D,
  input  logic [2:0]      ALUControl_D,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] Result_W,
  output logic [4:0]      Rs1_E,
  output logic [4:0]      Rs2_E,
  output logic [4:0]      Rd_E,
  output logic            ResultSrc0_E,
  output logic            PCSrc_E,
  output logic [XLEN-1:0] PCTarget_E,
  output logic [XLEN-1:0] ALUResult_M,
  output logic [XLEN-1:0] WriteData_M,
  output logic [XLEN-1:0] PCPlus4_M,
  output logic [4:0]      Rd_M,
  output logic            RegWrite_M,
  output logic            MemWrite_M,
  output logic [1:0]      ResultSrc_M
);
  localparam int SHW = $clog2(XLEN);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcp4;
    logic [14:0]     addr;
    logic [6:0]      ctrl;
    logic [2:0]      aluc;
  } idex_t;

  idex_t r_e;

  // Flush wins over stall; an all-zero entry is a harmless bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_e <= '0;
    else if (FlushE)  r_e <= '0;
    else if (!StallE) r_e <= '{rd1: RD1_D, rd2: RD2_D, imm: ImmExt_D, pc: PC_D,
                                pcp4: PCPlus4_D, addr: RegAddr_D, ctrl: Ctrl_D,
                                aluc: ALUControl_D};
  end

  logic            w_regw, w_memw, w_jump, w_branch, w_alusrc;
  logic [1:0]      w_rsrc;
  logic [XLEN-1:0] w_srca, w_fwdb, w_srcb, w_res;
  logic            w_zero;

  assign {w_regw, w_rsrc, w_memw, w_jump, w_branch, w_alusrc} = r_e.ctrl;

  // Code 11 is unused by the hazard unit and falls back to the register value.
  always_comb begin
    w_srca = r_e.rd1;
    w_fwdb = r_e.rd2;
    case (ForwardA_E)
      2'b01:   w_srca = Result_W;
      2'b10:   w_srca = ALUResult_M;
      default: w_srca = r_e.rd1;
    endcase
    case (ForwardB_E)
      2'b01:   w_fwdb = Result_W;
      2'b10:   w_fwdb = ALUResult_M;
      default: w_fwdb = r_e.rd2;
    endcase
  end

  assign w_srcb = w_alusrc ? r_e.imm : w_fwdb;

  always_comb begin
    w_res = '0;
    case (r_e.aluc)
      3'b000: w_res = w_srca + w_srcb;
      3'b001: w_res = w_srca - w_srcb;
      3'b010: w_res = w_srca & w_srcb;
      3'b011: w_res = w_srca | w_srcb;
      3'b100: w_res = w_srca << w_srcb[SHW-1:0];
      3'b101: w_res = {{(XLEN-1){1'b0}}, ($signed(w_srca) < $signed(w_srcb))};
      3'b110: w_res = w_srca >> w_srcb[SHW-1:0];
      3'b111: w_res = w_srca ^ w_srcb;
      default: w_res = '0;
    endcase
  end

  assign w_zero       = (w_res == '0);
  assign PCSrc_E      = (w_branch & w_zero) | w_jump;
  assign PCTarget_E   = r_e.pc + r_e.imm;
  assign Rs1_E        = r_e.addr[14:10];
  assign Rs2_E        = r_e.addr[9:5];
  assign Rd_E         = r_e.addr[4:0];
  assign ResultSrc0_E = w_rsrc[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUResult_M <= '0;
      WriteData_M <= '0;
      PCPlus4_M   <= '0;
      Rd_M        <= '0;
      RegWrite_M  <= 1'b0;
      MemWrite_M  <= 1'b0;
      ResultSrc_M <= '0;
    end else begin
      ALUResult_M <= w_res;
      WriteData_M <= w_fwdb;
      PCPlus4_M   <= r_e.pcp4;
      Rd_M        <= r_e.addr[4:0];
      RegWrite_M  <= w_regw;
      MemWrite_M  <= w_memw;
      ResultSrc_M <= w_rsrc;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus a randomized run
// against a field-level model of the two pipeline registers.
module tb_ex_stage;
  logic        clk, rst_n, StallE, FlushE;
  logic [31:0] RD1_D, RD2_D, ImmExt_D, PC_D, PCPlus4_D, Result_W;
  logic [14:0] RegAddr_D;
  logic [6:0]  Ctrl_D;
  logic [2:0]  ALUControl_D;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [4:0]  Rs1_E, Rs2_E, Rd_E, Rd_M;
  logic        ResultSrc0_E, PCSrc_E, RegWrite_M, MemWrite_M;
  logic [31:0] PCTarget_E, ALUResult_M, WriteData_M, PCPlus4_M;
  logic [1:0]  ResultSrc_M;

  int vectors = 0;
  int errors  = 0;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .ImmExt_D(ImmExt_D), .PC_D(PC_D),
    .PCPlus4_D(PCPlus4_D), .RegAddr_D(RegAddr_D), .Ctrl_D(Ctrl_D),
    .ALUControl_D(ALUControl_D), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .Result_W(Result_W), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .ResultSrc0_E(ResultSrc0_E), .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
    .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M),
    .Rd_M(Rd_M), .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M),
    .ResultSrc_M(ResultSrc_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction sitting in EX and the one sitting in MEM.
  logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pcp4;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic        e_regw, e_memw, e_jump, e_branch, e_alusrc;
  logic [1:0]  e_rsrc;
  logic [2:0]  e_aluc;
  logic [31:0] m_alu, m_wd, m_pcp4;
  logic [4:0]  m_rd;
  logic        m_regw, m_memw;
  logic [1:0]  m_rsrc;

  task automatic model_clear();
    {e_rd1, e_rd2, e_imm, e_pc, e_pcp4} = '0;
    {e_rs1, e_rs2, e_rd} = '0;
    {e_regw, e_memw, e_jump, e_branch, e_alusrc, e_rsrc, e_aluc} = '0;
    {m_alu, m_wd, m_pcp4, m_rd, m_regw, m_memw, m_rsrc} = '0;
  endtask

  function automatic logic [31:0] pick(input logic [1:0] code, input logic [31:0] regv);
    if (code == 2'd1) return Result_W;
    if (code == 2'd2) return m_alu;
    return regv;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a << (b % 32);
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a >> (b % 32);
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [31:0] ex_result();
    logic [31:0] b;
    b = e_alusrc ? e_imm : pick(ForwardB_E, e_rd2);
    return alu(e_aluc, pick(ForwardA_E, e_rd1), b);
  endfunction

  function automatic logic exp_pcsrc();
    return (e_branch && ex_result() == 32'd0) || e_jump;
  endfunction

  // Advance one clock: model the edge from the current inputs, then sample #1 later.
  task automatic tick();
    logic [31:0] n_alu, n_wd;
    n_alu = ex_result();
    n_wd  = pick(ForwardB_E, e_rd2);
    @(posedge clk); #1;
    m_alu = n_alu; m_wd = n_wd; m_pcp4 = e_pcp4; m_rd = e_rd;
    m_regw = e_regw; m_memw = e_memw; m_rsrc = e_rsrc;
    if (FlushE) begin
      {e_rd1, e_rd2, e_imm, e_pc, e_pcp4} = '0;
      {e_rs1, e_rs2, e_rd} = '0;
      {e_regw, e_memw, e_jump, e_branch, e_alusrc, e_rsrc, e_aluc} = '0;
    end else if (!StallE) begin
      e_rd1 = RD1_D; e_rd2 = RD2_D; e_imm = ImmExt_D; e_pc = PC_D; e_pcp4 = PCPlus4_D;
      e_rs1 = RegAddr_D[14:10]; e_rs2 = RegAddr_D[9:5]; e_rd = RegAddr_D[4:0];
      e_regw = Ctrl_D[6]; e_rsrc = Ctrl_D[5:4]; e_memw = Ctrl_D[3];
      e_jump = Ctrl_D[2]; e_branch = Ctrl_D[1]; e_alusrc = Ctrl_D[0];
      e_aluc = ALUControl_D;
    end
  endtask

  task automatic set_d(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [6:0] ctrl, input logic [2:0] aluc,
                       input logic [14:0] addr);
    RD1_D = rd1; RD2_D = rd2; ImmExt_D = imm; PC_D = pc; PCPlus4_D = pc + 32'd4;
    Ctrl_D = ctrl; ALUControl_D = aluc; RegAddr_D = addr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; StallE = 0; FlushE = 0; ForwardA_E = 0; ForwardB_E = 0; Result_W = 0;
    set_d(32'h1234, 32'h55, 32'h8, 32'h400, 7'h7F, 3'd0, 15'h7FFF);
    model_clear();
    #3;
    vectors++;
    if ({Rs1_E, Rs2_E, Rd_E, ResultSrc0_E, PCTarget_E, ALUResult_M, WriteData_M, PCPlus4_M,
         Rd_M, RegWrite_M, MemWrite_M, ResultSrc_M} !== '0) begin
      errors++; $display("FAIL reset_regs: got Rd_E=%h ALUResult_M=%h PCPlus4_M=%h, expected all 0",
                         Rd_E, ALUResult_M, PCPlus4_M);
    end
    vectors++;
    if (PCSrc_E !== 1'b0) begin errors++; $display("FAIL reset_pcsrc: got %b expected 0", PCSrc_E); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    set_d(32'd5, 32'd7, 32'd0, 32'h0, 7'b1000000, 3'd0, {5'd1, 5'd2, 5'd3});
    tick();
    vectors++;
    if (Rd_E !== 5'd3) begin errors++; $display("FAIL add_rd_e: got %0d expected 3", Rd_E); end
    tick();
    vectors++;
    if (ALUResult_M !== 32'd12 || RegWrite_M !== 1'b1) begin
      errors++; $display("FAIL add_m: got ALUResult_M=%0d RegWrite_M=%b expected 12/1", ALUResult_M, RegWrite_M);
    end
  endtask

  task automatic test_branch();
    set_d(32'h10, 32'h10, 32'h20, 32'h100, 7'b0000010, 3'd1, 15'd0);
    tick();
    vectors++;
    if (PCSrc_E !== 1'b1 || PCTarget_E !== 32'h120) begin
      errors++; $display("FAIL branch_taken: got PCSrc_E=%b PCTarget_E=%h expected 1/120", PCSrc_E, PCTarget_E);
    end
    RD2_D = 32'h11;
    tick();
    vectors++;
    if (PCSrc_E !== 1'b0) begin errors++; $display("FAIL branch_not_taken: got %b expected 0", PCSrc_E); end
  endtask

  task automatic test_forward();
    set_d(32'd5, 32'd7, 32'd0, 32'h0, 7'b1000000, 3'd0, 15'd0);
    tick();
    set_d(32'd99, 32'd3, 32'd0, 32'h0, 7'b1000000, 3'd0, 15'd0);
    tick();
    ForwardA_E = 2'b10;
    tick();
    vectors++;
    if (ALUResult_M !== 32'd15) begin errors++; $display("FAIL fwd_a_mem: got %0d expected 15", ALUResult_M); end
    ForwardA_E = 2'b00;
    set_d(32'd0, 32'd5, 32'd0, 32'h0, 7'b1000000, 3'd5, 15'd0);
    tick();
    ForwardB_E = 2'b01; Result_W = 32'hFFFF_FFFF;
    tick();
    vectors++;
    if (ALUResult_M !== 32'd0 || WriteData_M !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL fwd_b_wb_slt: got res=%h wd=%h expected 0/ffffffff", ALUResult_M, WriteData_M);
    end
    ForwardB_E = 2'b00;
    set_d(32'd9, 32'd4, 32'd0, 32'h0, 7'b1000000, 3'd0, 15'd0);
    tick();
    ForwardA_E = 2'b11;
    tick();
    vectors++;
    if (ALUResult_M !== 32'd13) begin errors++; $display("FAIL fwd_a_11: got %0d expected 13", ALUResult_M); end
    ForwardA_E = 2'b00;
  endtask

  task automatic test_shift_logic();
    logic [31:0] ta [5] = '{32'd1, 32'h8000_0000, 32'hF0F0, 32'hF0F0, 32'hF0F0};
    logic [31:0] tb [5] = '{32'h21, 32'd31, 32'hFF00, 32'hFF00, 32'hFF00};
    logic [2:0]  op [5] = '{3'd4, 3'd6, 3'd7, 3'd2, 3'd3};
    logic [31:0] ex [5] = '{32'd2, 32'd1, 32'h0FF0, 32'hF000, 32'hFFF0};
    for (int i = 0; i < 5; i++) begin
      set_d(ta[i], tb[i], 32'd0, 32'h0, 7'b1000000, op[i], 15'd0);
      tick(); tick();
      vectors++;
      if (ALUResult_M !== ex[i]) begin
        errors++; $display("FAIL shift_logic[%0d]: got %h expected %h", i, ALUResult_M, ex[i]);
      end
    end
  endtask

  task automatic test_hazards();
    set_d(32'd20, 32'd1, 32'd0, 32'h0, 7'b1000000, 3'd1, {5'd4, 5'd5, 5'd7});
    tick();
    set_d(32'd0, 32'd0, 32'd0, 32'h0, 7'b1000000, 3'd0, {5'd0, 5'd0, 5'd9});
    StallE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (Rd_E !== 5'd7 || ALUResult_M !== 32'd19 || Rd_M !== 5'd7) begin
        errors++; $display("FAIL stall_hold[%0d]: got Rd_E=%0d res=%0d Rd_M=%0d expected 7/19/7",
                           i, Rd_E, ALUResult_M, Rd_M);
      end
    end
    StallE = 1'b0;
    tick();
    vectors++;
    if (Rd_E !== 5'd9) begin errors++; $display("FAIL stall_release: got %0d expected 9", Rd_E); end
    set_d(32'd1, 32'd1, 32'd0, 32'h0, 7'b1111111, 3'd1, 15'h7FFF);
    StallE = 1'b1; FlushE = 1'b1;
    tick();
    StallE = 1'b0; FlushE = 1'b0;
    vectors++;
    if (Rd_E !== 5'd0 || PCSrc_E !== 1'b0) begin
      errors++; $display("FAIL flush_bubble_e: got Rd_E=%0d PCSrc_E=%b expected 0/0", Rd_E, PCSrc_E);
    end
    Ctrl_D = 7'b0000000;
    tick();
    vectors++;
    if (RegWrite_M !== 1'b0 || MemWrite_M !== 1'b0 || Rd_M !== 5'd0) begin
      errors++; $display("FAIL flush_bubble_m: got RegWrite_M=%b MemWrite_M=%b Rd_M=%0d expected 0", RegWrite_M, MemWrite_M, Rd_M);
    end
  endtask

  task automatic test_async_reset();
    set_d(32'd3, 32'd4, 32'h40, 32'h200, 7'b1111100, 3'd0, {5'd1, 5'd2, 5'd6});
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    vectors++;
    if ({Rs1_E, Rs2_E, Rd_E, ResultSrc0_E, PCSrc_E, PCTarget_E, ALUResult_M, WriteData_M,
         PCPlus4_M, Rd_M, RegWrite_M, MemWrite_M, ResultSrc_M} !== '0) begin
      errors++; $display("FAIL async_reset: got Rd_E=%0d PCSrc_E=%b PCTarget_E=%h ALUResult_M=%h expected 0",
                         Rd_E, PCSrc_E, PCTarget_E, ALUResult_M);
    end
    @(negedge clk); rst_n = 1'b1;
    set_d(32'd8, 32'd2, 32'd0, 32'h0, 7'b1000000, 3'd0, {5'd0, 5'd0, 5'd11});
    tick();
    vectors++;
    if (Rd_E !== 5'd11) begin errors++; $display("FAIL post_reset_capture: got %0d expected 11", Rd_E); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r1;
      r1 = $urandom;
      set_d(r1, ($urandom_range(0, 3) == 0) ? r1 : $urandom,
            ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : $urandom,
            $urandom, 7'($urandom), 3'($urandom), 15'($urandom));
      StallE = ($urandom_range(0, 4) == 0);
      FlushE = ($urandom_range(0, 9) == 0);
      ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom);
      Result_W = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      tick();
      vectors++;
      if ({Rs1_E, Rs2_E, Rd_E, ResultSrc0_E, PCSrc_E, PCTarget_E} !==
          {e_rs1, e_rs2, e_rd, e_rsrc[0], exp_pcsrc(), e_pc + e_imm}) begin
        errors++; $display("FAIL rand_e[%0d]: got rs=%0d/%0d rd=%0d rs0=%b pcsrc=%b tgt=%h expected %0d/%0d %0d %b %b %h",
                           n, Rs1_E, Rs2_E, Rd_E, ResultSrc0_E, PCSrc_E, PCTarget_E,
                           e_rs1, e_rs2, e_rd, e_rsrc[0], exp_pcsrc(), e_pc + e_imm);
      end
      vectors++;
      if ({ALUResult_M, WriteData_M, PCPlus4_M, Rd_M, RegWrite_M, MemWrite_M, ResultSrc_M} !==
          {m_alu, m_wd, m_pcp4, m_rd, m_regw, m_memw, m_rsrc}) begin
        errors++; $display("FAIL rand_m[%0d]: got res=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b rs=%0d expected %h %h %h %0d %b %b %0d",
                           n, ALUResult_M, WriteData_M, PCPlus4_M, Rd_M, RegWrite_M, MemWrite_M, ResultSrc_M,
                           m_alu, m_wd, m_pcp4, m_rd, m_regw, m_memw, m_rsrc);
      end
    end
    StallE = 0; FlushE = 0; ForwardA_E = 0; ForwardB_E = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_forward();
    test_shift_logic();
    test_hazards();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
